// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SdramCtrl between two requesters in the SDRAM clock domain.
// Round-robin grant, held until the controller reports completion, then a
// one-cycle release gap so the controller never sees a back-to-back strobe.
// Read data is latched per port; a watchdog aborts operations that hang.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // port 0
    input  logic                  rd0_i,
    input  logic                  wr0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] data0_i,
    output logic [DATA_WIDTH-1:0] data0_o,
    output logic                  done0_o,
    output logic                  err0_o,
    // port 1
    input  logic                  rd1_i,
    input  logic                  wr1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic                  done1_o,
    output logic                  err1_o,
    // SdramCtrl side
    output logic                  rd_o,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  opBegun_i,
    input  logic                  done_i,
    input  logic                  rdDone_i
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] WDOG_MAX  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] WDOG_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } stateT;

    stateT                 stateR, stateNxt;
    logic                  grantR, grantNxt;      // port currently owning the controller
    logic                  isWrR, isWrNxt;        // captured operation type
    logic                  lastR, lastNxt;        // last-served port, loses the next tie
    logic [CNT_WIDTH-1:0]  wdogR, wdogNxt;
    logic [ADDR_WIDTH-1:0] addrR, addrNxt;
    logic [DATA_WIDTH-1:0] wrDataR, wrDataNxt;
    logic                  rdR, rdNxt;
    logic                  wrR, wrNxt;
    logic                  done0R, done0Nxt;
    logic                  done1R, done1Nxt;
    logic                  err0R, err0Nxt;
    logic                  err1R, err1Nxt;
    logic [DATA_WIDTH-1:0] rdData0R, rdData0Nxt;
    logic [DATA_WIDTH-1:0] rdData1R, rdData1Nxt;

    logic req0S, req1S, pickS, complS, timeoutS;

    // The controller's operation-started flag carries no information we need.
    logic unusedOpBegun;
    assign unusedOpBegun = opBegun_i;

    assign req0S    = rd0_i | wr0_i;
    assign req1S    = rd1_i | wr1_i;
    // On a tie the port that was not served last wins.
    assign pickS    = (req0S & req1S) ? ~lastR : req1S;
    assign complS   = isWrR ? done_i : rdDone_i;
    // This BUSY cycle is the TIMEOUT-th one since the grant.
    assign timeoutS = (wdogR >= WDOG_LAST);

    // Next-state and next register values for the arbitration FSM
    always_comb begin
        stateNxt   = stateR;
        grantNxt   = grantR;
        isWrNxt    = isWrR;
        lastNxt    = lastR;
        wdogNxt    = wdogR;
        addrNxt    = addrR;
        wrDataNxt  = wrDataR;
        rdNxt      = 1'b0;
        wrNxt      = 1'b0;
        done0Nxt   = 1'b0;
        done1Nxt   = 1'b0;
        err0Nxt    = 1'b0;
        err1Nxt    = 1'b0;
        rdData0Nxt = rdData0R;
        rdData1Nxt = rdData1R;
        case (stateR)
            IDLE: begin
                if (req0S || req1S) begin
                    grantNxt  = pickS;
                    // a simultaneous rd and wr is treated as a write
                    isWrNxt   = pickS ? wr1_i : wr0_i;
                    addrNxt   = pickS ? addr1_i : addr0_i;
                    wrDataNxt = pickS ? data1_i : data0_i;
                    wdogNxt   = {CNT_WIDTH{1'b0}};
                    rdNxt     = ~isWrNxt;
                    wrNxt     = isWrNxt;
                    stateNxt  = BUSY;
                end else begin
                    stateNxt  = IDLE;
                end
            end
            BUSY: begin
                if (complS) begin
                    // completion beats a timeout landing in the same cycle
                    done0Nxt   = ~grantR;
                    done1Nxt   = grantR;
                    rdData0Nxt = (!isWrR && !grantR) ? data_i : rdData0R;
                    rdData1Nxt = (!isWrR && grantR) ? data_i : rdData1R;
                    lastNxt    = grantR;
                    stateNxt   = RELEASE;
                end else if (timeoutS) begin
                    err0Nxt    = ~grantR;
                    err1Nxt    = grantR;
                    lastNxt    = grantR;
                    wdogNxt    = (wdogR != WDOG_MAX) ? (wdogR + WDOG_ONE) : wdogR;
                    stateNxt   = RELEASE;
                end else begin
                    rdNxt      = ~isWrR;
                    wrNxt      = isWrR;
                    wdogNxt    = (wdogR != WDOG_MAX) ? (wdogR + WDOG_ONE) : wdogR;
                    stateNxt   = BUSY;
                end
            end
            RELEASE: begin
                // strobes already low; one quiet cycle before the next grant
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNxt;
        end
    end

    // Captured request, arbitration history, watchdog and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grantR   <= 1'b0;
            isWrR    <= 1'b0;
            lastR    <= 1'b1;
            wdogR    <= {CNT_WIDTH{1'b0}};
            addrR    <= {ADDR_WIDTH{1'b0}};
            wrDataR  <= {DATA_WIDTH{1'b0}};
            rdR      <= 1'b0;
            wrR      <= 1'b0;
            done0R   <= 1'b0;
            done1R   <= 1'b0;
            err0R    <= 1'b0;
            err1R    <= 1'b0;
            rdData0R <= {DATA_WIDTH{1'b0}};
            rdData1R <= {DATA_WIDTH{1'b0}};
        end else begin
            grantR   <= grantNxt;
            isWrR    <= isWrNxt;
            lastR    <= lastNxt;
            wdogR    <= wdogNxt;
            addrR    <= addrNxt;
            wrDataR  <= wrDataNxt;
            rdR      <= rdNxt;
            wrR      <= wrNxt;
            done0R   <= done0Nxt;
            done1R   <= done1Nxt;
            err0R    <= err0Nxt;
            err1R    <= err1Nxt;
            rdData0R <= rdData0Nxt;
            rdData1R <= rdData1Nxt;
        end
    end

    assign rd_o    = rdR;
    assign wr_o    = wrR;
    assign addr_o  = addrR;
    assign data_o  = wrDataR;
    assign done0_o = done0R;
    assign done1_o = done1R;
    assign err0_o  = err0R;
    assign err1_o  = err1R;
    assign data0_o = rdData0R;
    assign data1_o = rdData1R;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Scoreboard bench: a transaction-level reference model predicts each
// controller operation and each done/err pulse into queues; an independent
// monitor pops and compares when the DUT shows them.
module tb_sdram_arbiter;

    localparam int AW = 23;
    localparam int DW = 16;
    localparam int TO = 15;

    typedef struct {
        int            port;
        logic          isWr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } opExpT;

    typedef struct {
        int            port;
        logic          isErr;
        logic          isRd;
        logic [DW-1:0] data;
        int            cyc;
    } respExpT;

    logic          clkDut = 1'b0;
    logic          rst;
    logic [1:0]    rdReq, wrReq;
    logic [AW-1:0] addrReq [2];
    logic [DW-1:0] dataReq [2];
    logic [DW-1:0] data0Out, data1Out;
    logic          done0, done1, err0, err1;
    logic          rdOut, wrOut;
    logic [AW-1:0] addrOut;
    logic [DW-1:0] dataOut;
    logic [DW-1:0] dataIn;
    logic          opBegunIn, doneIn, rdDoneIn, spurDone;
    logic          doneLine;
    logic [1:0]    doneOut, errOut;

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;
    int fixedLat = 6;     // 0 selects a random latency per operation
    logic rdFixed = 1'b1; // read completions return 16'hBEEF

    opExpT   opQ[$];
    respExpT respQ[$];

    assign doneLine = doneIn | spurDone;
    assign doneOut  = {done1, done0};
    assign errOut   = {err1, err0};

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clkDut), .rst_i(rst),
        .rd0_i(rdReq[0]), .wr0_i(wrReq[0]), .addr0_i(addrReq[0]), .data0_i(dataReq[0]),
        .data0_o(data0Out), .done0_o(done0), .err0_o(err0),
        .rd1_i(rdReq[1]), .wr1_i(wrReq[1]), .addr1_i(addrReq[1]), .data1_i(dataReq[1]),
        .data1_o(data1Out), .done1_o(done1), .err1_o(err1),
        .rd_o(rdOut), .wr_o(wrOut), .addr_o(addrOut), .data_o(dataOut),
        .data_i(dataIn), .opBegun_i(opBegunIn), .done_i(doneLine), .rdDone_i(rdDoneIn)
    );

    // clock
    always #5 clkDut = ~clkDut;

    // cycle counter used to timestamp predictions and observations
    always @(posedge clkDut) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clkDut);
        #1;
    endtask

    task automatic issue(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rdReq[p]   = r;
        wrReq[p]   = w;
        addrReq[p] = a;
        dataReq[p] = d;
    endtask

    // hold the request until this port sees done or err, then drop it
    task automatic waitDone(input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (doneOut[p] || errOut[p]) begin
                seen = 1'b1;
                break;
            end
        end
        rdReq[p] = 1'b0;
        wrReq[p] = 1'b0;
        if (!seen) chk("waitDoneBound", 64'd0, 64'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic randPort(input int p, input int n);
        int kind;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) tick();
            kind = int'($urandom_range(0, 3));   // 0,1 read, 2 write, 3 rd+wr
            issue(p, kind != 2, kind >= 2, AW'($urandom), DW'($urandom));
            waitDone(p);
        end
    endtask

    // SdramCtrl stand-in: completes each operation after its chosen latency
    initial begin
        int rsCnt;
        int rsLat;
        bit rsActive;
        doneIn = 1'b0; rdDoneIn = 1'b0; opBegunIn = 1'b0; dataIn = '0;
        rsActive = 1'b0; rsCnt = 0; rsLat = 1;
        forever begin
            tick();
            doneIn    = 1'b0;
            rdDoneIn  = 1'b0;
            opBegunIn = 1'b0;
            dataIn    = DW'($urandom);
            if (rst || !(rdOut || wrOut)) begin
                rsActive = 1'b0;
            end else begin
                if (!rsActive) begin
                    rsActive  = 1'b1;
                    rsCnt     = 0;
                    rsLat     = (fixedLat != 0) ? fixedLat : int'($urandom_range(1, 18));
                    opBegunIn = 1'b1;
                end
                rsCnt++;
                if (rsCnt == rsLat) begin
                    if (wrOut) doneIn = 1'b1;
                    else begin
                        rdDoneIn = 1'b1;
                        dataIn   = rdFixed ? 16'hBEEF : DW'($urandom);
                    end
                end
            end
        end
    end

    // Reference model: grant order, operation contents and outcome timing
    initial begin
        bit    pBusy;
        int    pIdleAt;
        int    pLast;
        int    pPort;
        opExpT pCur;
        pBusy = 1'b0; pIdleAt = 0; pLast = 1; pPort = 0;
        forever begin
            @(negedge clkDut);
            if (rst) begin
                opQ.delete();
                respQ.delete();
                pBusy   = 1'b0;
                pIdleAt = 0;
                pLast   = 1;
            end else if (pBusy) begin
                if (pCur.isWr ? doneLine : rdDoneIn) begin
                    respQ.push_back('{pCur.port, 1'b0, !pCur.isWr, dataIn, cyc + 1});
                    pBusy = 1'b0; pIdleAt = cyc + 2; pLast = pCur.port;
                end else if (cyc == pCur.cyc + TO - 1) begin
                    respQ.push_back('{pCur.port, 1'b1, !pCur.isWr, 16'h0000, cyc + 1});
                    pBusy = 1'b0; pIdleAt = cyc + 2; pLast = pCur.port;
                end
            end else if (cyc >= pIdleAt && (rdReq[0] || wrReq[0] || rdReq[1] || wrReq[1])) begin
                if ((rdReq[0] || wrReq[0]) && (rdReq[1] || wrReq[1])) pPort = 1 - pLast;
                else pPort = (rdReq[1] || wrReq[1]) ? 1 : 0;
                pCur = '{pPort, wrReq[pPort], addrReq[pPort], dataReq[pPort], cyc + 1};
                opQ.push_back(pCur);
                pBusy = 1'b1;
            end
        end
    end

    // Monitor: compares what the DUT presents against the queued predictions
    initial begin
        bit            prevBus;
        logic [DW-1:0] sh0, sh1;
        opExpT         e;
        respExpT       r;
        prevBus = 1'b0; sh0 = '0; sh1 = '0;
        forever begin
            @(negedge clkDut);
            if (rst) begin
                chk("rstCtrlOut", {rdOut, wrOut, doneOut, errOut, addrOut}, 64'd0);
                chk("rstDataOut", {dataOut, data0Out, data1Out}, 64'd0);
                prevBus = 1'b0; sh0 = '0; sh1 = '0;
            end else begin
                if (rdOut && wrOut) chk("rdWrExclusive", {rdOut, wrOut}, 64'd1);
                if ((rdOut || wrOut) && !prevBus) begin
                    if (opQ.size() == 0) chk("opUnexpected", {rdOut, wrOut}, 64'd0);
                    else begin
                        e = opQ.pop_front();
                        chk("opCycle", cyc, e.cyc);
                        chk("opType", {rdOut, wrOut}, {!e.isWr, e.isWr});
                        chk("opAddr", addrOut, e.addr);
                        if (e.isWr) chk("opData", dataOut, e.data);
                    end
                end
                if (doneOut != 2'b00 || errOut != 2'b00) begin
                    chk("releaseBusLow", {rdOut, wrOut}, 64'd0);
                    if (respQ.size() == 0) chk("respUnexpected", {errOut, doneOut}, 64'd0);
                    else begin
                        r = respQ.pop_front();
                        chk("respCycle", cyc, r.cyc);
                        chk("doneVec", doneOut, r.isErr ? 2'b00 : ((r.port == 1) ? 2'b10 : 2'b01));
                        chk("errVec", errOut, !r.isErr ? 2'b00 : ((r.port == 1) ? 2'b10 : 2'b01));
                        if (!r.isErr && r.isRd) begin
                            if (r.port == 1) sh1 = r.data;
                            else sh0 = r.data;
                        end
                    end
                end
                chk("data0Hold", data0Out, sh0);
                chk("data1Hold", data1Out, sh1);
                prevBus = rdOut || wrOut;
            end
        end
    end

    // Stimulus sequence
    initial begin
        rst = 1'b1; rdReq = 2'b00; wrReq = 2'b00; spurDone = 1'b0;
        addrReq[0] = '0; addrReq[1] = '0; dataReq[0] = '0; dataReq[1] = '0;
        doReset();

        // single read on port 0
        fixedLat = 6; rdFixed = 1'b1;
        issue(0, 1'b1, 1'b0, 23'h000123, 16'h0000);
        waitDone(0);
        chk("singleRdData", data0Out, 16'hBEEF);
        rdFixed = 1'b0;

        // simultaneous writes after reset, then renewed contention
        doReset();
        fixedLat = 3;
        issue(0, 1'b0, 1'b1, 23'h000010, 16'h1111);
        issue(1, 1'b0, 1'b1, 23'h000020, 16'h2222);
        fork
            begin waitDone(0); issue(0, 1'b0, 1'b1, 23'h000030, 16'h3333); waitDone(0); end
            begin waitDone(1); issue(1, 1'b0, 1'b1, 23'h000040, 16'h4444); waitDone(1); end
        join

        // port 1 read stalls; port 0 waits and is granted afterwards
        fixedLat = 1000;
        issue(1, 1'b1, 1'b0, 23'h000055, 16'h0000);
        repeat (3) tick();
        fixedLat = 4;
        issue(0, 1'b0, 1'b1, 23'h000066, 16'h6666);
        fork
            waitDone(1);
            waitDone(0);
        join

        // rd and wr together, completion on the timeout cycle, spurious done
        fixedLat = 2;
        issue(0, 1'b1, 1'b1, 23'h000077, 16'h7777);
        waitDone(0);
        fixedLat = TO;
        issue(0, 1'b1, 1'b0, 23'h000088, 16'h0000);
        waitDone(0);
        repeat (2) tick();
        spurDone = 1'b1;
        tick();
        spurDone = 1'b0;
        repeat (3) tick();

        // reset while a port 1 write is in flight, port 0 pending
        fixedLat = 1000;
        issue(1, 1'b0, 1'b1, 23'h000099, 16'h9999);
        repeat (3) tick();
        issue(0, 1'b1, 1'b0, 23'h0000AA, 16'h0000);
        @(posedge clkDut);
        #3 rst = 1'b1;
        #1 chk("rstAsyncWr", wrOut, 1'b0);
        fixedLat = 3;
        repeat (2) @(posedge clkDut);
        #1 rst = 1'b0;
        fork
            waitDone(0);
            waitDone(1);
        join

        // back-to-back reads on port 0
        fixedLat = 5;
        for (int k = 0; k < 3; k++) begin
            issue(0, 1'b1, 1'b0, AW'(32'h100 + k), 16'h0000);
            waitDone(0);
        end

        // randomized traffic on both ports
        fixedLat = 0;
        fork
            randPort(0, 40);
            randPort(1, 40);
        join
        repeat (20) tick();
        chk("opQueueDrained", opQ.size(), 64'd0);
        chk("respQueueDrained", respQ.size(), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
